// File: rtl/conv1d_dma_pkg.sv
// FSM states and direction encodings of the conv1d OBI DMA.
package conv1d_dma_pkg;

    localparam int unsigned LenWidthDefault = 8;

    localparam logic DirLoad  = 1'b0;
    localparam logic DirStore = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SRAM_RD,
        SRAM_LAT,
        OBI_REQ,
        OBI_RSP,
        DONE
    } dma_state_e;

endpackage

// File: rtl/conv1d_sram_pkg.sv
// Request type of the conv1d internal SRAM port.
package conv1d_sram_pkg;

    localparam int unsigned SramAddrWidth = 7;

    typedef struct packed {
        logic                     req;
        logic                     we;
        logic [SramAddrWidth-1:0] addr;
        logic [31:0]              wdata;
        logic [3:0]               be;
    } sram_req_t;

endpackage

// File: rtl/croc_pkg.sv
// OBI manager request/response types used on the croc crossbar.
package croc_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } mgr_obi_rsp_t;

endpackage

// File: rtl/conv1d_obi_dma.sv
// Single-outstanding OBI manager that copies word blocks between system
// memory and the conv1d internal SRAM, in either direction.
module conv1d_obi_dma
    import croc_pkg::*;
    import conv1d_sram_pkg::*;
    import conv1d_dma_pkg::*;
#(
    parameter int unsigned NumWords  = 128,
    parameter int unsigned AddrWidth = $clog2(NumWords),
    parameter int unsigned LenWidth  = LenWidthDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 dir_i,
    input  logic [31:0]          ext_addr_i,
    input  logic [AddrWidth-1:0] sram_addr_i,
    input  logic [LenWidth-1:0]  len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output mgr_obi_req_t         obi_req_o,
    input  mgr_obi_rsp_t         obi_rsp_i,
    output sram_req_t            sram_req_o,
    input  logic [31:0]          sram_rdata_i
);

    localparam logic [LenWidth:0]    MaxLen  = (LenWidth + 1)'(NumWords);
    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumWords - 1);

    dma_state_e           state_q, state_d;
    logic                 dir_q, dir_d;
    logic [31:0]          ext_addr_q, ext_addr_d;
    logic [AddrWidth-1:0] sram_idx_q, sram_idx_d;
    logic [LenWidth-1:0]  remaining_q, remaining_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic [LenWidth-1:0]  len_clamped;

    assign len_clamped = ({1'b0, len_i} > MaxLen) ? MaxLen[LenWidth-1:0] : len_i;

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            dir_q       <= DirLoad;
            ext_addr_q  <= '0;
            sram_idx_q  <= '0;
            remaining_q <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            ext_addr_q  <= ext_addr_d;
            sram_idx_q  <= sram_idx_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        ext_addr_d  = ext_addr_q;
        sram_idx_d  = sram_idx_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        obi_req_o   = '0;
        sram_req_o  = '0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    dir_d       = dir_i;
                    ext_addr_d  = {ext_addr_i[31:2], 2'b00};
                    sram_idx_d  = sram_addr_i;
                    remaining_d = len_clamped;
                    err_d       = 1'b0;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else if (dir_i == DirStore) begin
                        state_d = SRAM_RD;
                    end else begin
                        state_d = OBI_REQ;
                    end
                end
            end
            SRAM_RD: begin
                sram_req_o.req  = 1'b1;
                sram_req_o.addr = SramAddrWidth'(sram_idx_q);
                state_d         = SRAM_LAT;
            end
            SRAM_LAT: begin
                wdata_d = sram_rdata_i;
                state_d = OBI_REQ;
            end
            OBI_REQ: begin
                // Request fields depend only on registered state, so they stay
                // stable for as long as the grant is withheld.
                obi_req_o.req    = 1'b1;
                obi_req_o.a.addr = ext_addr_q;
                obi_req_o.a.be   = 4'hF;
                obi_req_o.a.we   = (dir_q == DirStore);
                obi_req_o.a.wdata = (dir_q == DirStore) ? wdata_q : 32'h0;
                if (obi_rsp_i.gnt) begin
                    state_d = OBI_RSP;
                end
            end
            OBI_RSP: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.r.err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        if (dir_q == DirLoad) begin
                            sram_req_o.req   = 1'b1;
                            sram_req_o.we    = 1'b1;
                            sram_req_o.be    = 4'hF;
                            sram_req_o.addr  = SramAddrWidth'(sram_idx_q);
                            sram_req_o.wdata = obi_rsp_i.r.rdata;
                        end
                        ext_addr_d  = ext_addr_q + 32'd4;
                        sram_idx_d  = (sram_idx_q == LastIdx) ? '0 : sram_idx_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == LenWidth'(1)) begin
                            state_d = DONE;
                        end else if (dir_q == DirStore) begin
                            state_d = SRAM_RD;
                        end else begin
                            state_d = OBI_REQ;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv1d_obi_dma.sv
// Scoreboard bench for conv1d_obi_dma: stimulus queues expected SRAM writes,
// OBI writes, done pulses and status snapshots; a monitor pops and compares.
module tb_conv1d_obi_dma;
    import croc_pkg::*;
    import conv1d_sram_pkg::*;
    import conv1d_dma_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic         dir_i;
    logic [31:0]  ext_addr_i;
    logic [6:0]   sram_addr_i;
    logic [7:0]   len_i;
    logic         busy_o, done_o, err_o;
    mgr_obi_req_t obi_req;
    mgr_obi_rsp_t obi_rsp;
    sram_req_t    sram_req;
    logic [31:0]  sram_rdata;

    always #5 clk = ~clk;

    conv1d_obi_dma dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .dir_i        (dir_i),
        .ext_addr_i   (ext_addr_i),
        .sram_addr_i  (sram_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .obi_req_o    (obi_req),
        .obi_rsp_i    (obi_rsp),
        .sram_req_o   (sram_req),
        .sram_rdata_i (sram_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // System memory model: grant combinational, response one cycle later.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_n = 0;
    int          stall_cnt = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        gnt, rvalid_q, rerr_q;
    logic [31:0] rdata_q;

    assign gnt = obi_req.req && !(obi_req.a.addr == stall_addr && stall_cnt < stall_n);

    always @(posedge clk) begin
        if (obi_req.req && !gnt) stall_cnt <= stall_cnt + 1;
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= obi_req.req && gnt;
            if (obi_req.req && gnt) begin
                rdata_q <= mem.exists(obi_req.a.addr) ? mem[obi_req.a.addr] : 32'hDEAD_BEEF;
                rerr_q  <= (obi_req.a.addr == err_addr);
            end
        end
    end

    always_comb begin
        obi_rsp         = '0;
        obi_rsp.gnt     = gnt;
        obi_rsp.rvalid  = rvalid_q;
        obi_rsp.r.rdata = rdata_q;
        obi_rsp.r.err   = rerr_q && rvalid_q;
    end

    // Internal SRAM read model (writes are observed by the monitor).
    logic [31:0] sram_init [128];
    always @(posedge clk) begin
        if (sram_req.req && !sram_req.we) sram_rdata <= sram_init[sram_req.addr];
    end

    typedef struct {
        int          kind;   // 0 SRAM write, 1 OBI write, 2 done pulse (addr = cycle)
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;
    typedef struct {
        int   c;
        logic [4:0] st;      // {busy, done, err, obi req, sram req}
    } st_t;

    ev_t  ev_q[$];
    st_t  st_q[$];
    logic end_req = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic pop_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected event kind %0d @cyc %0d: got addr %h data %h, expected none",
                     kind, cyc, addr, data);
        end else begin
            e = ev_q.pop_front();
            check("event kind", kind, e.kind);
            check($sformatf("event%0d addr", kind), addr, e.addr);
            check($sformatf("event%0d data", kind), data, e.data);
            $display("txn kind %0d addr %h data %h @cyc %0d", kind, addr, data, cyc);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic        prev_we;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        st_t s;
        if (prev_stall) begin
            check("stalled a.addr stable", obi_req.a.addr, prev_addr);
            check("stalled a.we stable", {31'b0, obi_req.a.we}, {31'b0, prev_we});
            check("stalled a.wdata stable", obi_req.a.wdata, prev_wdata);
            check("stalled req held", {31'b0, obi_req.req}, 32'd1);
        end
        prev_stall = obi_req.req && !gnt;
        prev_addr  = obi_req.a.addr;
        prev_we    = obi_req.a.we;
        prev_wdata = obi_req.a.wdata;

        if (sram_req.req && sram_req.we) begin
            check("sram be", {28'b0, sram_req.be}, 32'hF);
            pop_ev(0, {25'b0, sram_req.addr}, sram_req.wdata);
        end
        if (obi_req.req && gnt && obi_req.a.we) begin
            check("obi be", {28'b0, obi_req.a.be}, 32'hF);
            pop_ev(1, obi_req.a.addr, obi_req.a.wdata);
        end
        if (done_o) pop_ev(2, cyc, 32'h0);

        while (st_q.size() > 0 && st_q[0].c <= cyc) begin
            s = st_q.pop_front();
            if (s.c < cyc) check("status missed", cyc, s.c);
            else check("status {busy,done,err,oreq,sreq}",
                       {27'b0, busy_o, done_o, err_o, obi_req.req, sram_req.req}, {27'b0, s.st});
        end

        if (end_req || cyc > 20000) begin
            if (cyc > 20000) check("timeout", cyc, 32'd20000);
            check("leftover events", ev_q.size(), 32'd0);
            check("leftover status", st_q.size(), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        ev_q.push_back(e);
    endtask

    task automatic push_st(input int c, input logic [4:0] st);
        st_t s;
        s.c  = c;
        s.st = st;
        st_q.push_back(s);
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic start_xfer(input logic d, input logic [31:0] ea, input logic [6:0] sa,
                              input logic [7:0] ln);
        dir_i       = d;
        ext_addr_i  = ea;
        sram_addr_i = sa;
        len_i       = ln;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    initial begin
        int c0;
        rst_ni = 1'b0;
        start_i = 1'b0;
        dir_i = 1'b0;
        ext_addr_i = '0;
        sram_addr_i = '0;
        len_i = '0;
        for (int i = 0; i < 128; i++) sram_init[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[32'h1000 + 4 * i] = 32'hA0 + i;
        for (int i = 0; i < 4; i++) mem[32'h3000 + 4 * i] = 32'hB0 + i;
        for (int i = 0; i < 5; i++) mem[32'h4000 + 4 * i] = 32'hC0 + i;
        mem[32'h5000] = 32'h11;
        mem[32'h5004] = 32'h22;
        sram_init[5] = 32'd1;
        sram_init[6] = 32'd2;
        sram_init[7] = 32'd3;

        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        push_st(cyc + 1, 5'b00000);
        @(negedge clk);

        // Load 4 words into SRAM 0x10.
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 4; i++) push_ev(0, 32'h10 + i, 32'hA0 + i);
        push_ev(2, c0 + 9, 0);
        push_st(c0 + 1, 5'b10010);
        push_st(c0 + 9, 5'b11000);
        push_st(c0 + 10, 5'b00000);
        start_xfer(DirLoad, 32'h1000, 7'h10, 8'd4);
        repeat (12) @(negedge clk);

        // Store SRAM[5..7] to 0x2000 (ext address bits [1:0] ignored).
        c0 = cyc;
        for (int i = 0; i < 3; i++) push_ev(1, 32'h2000 + 4 * i, i + 1);
        push_ev(2, c0 + 13, 0);
        push_st(c0 + 1, 5'b10001);
        push_st(c0 + 3, 5'b10010);
        start_xfer(DirStore, 32'h2003, 7'd5, 8'd3);
        repeat (15) @(negedge clk);

        // Grant withheld 3 cycles on word 1 of a 2-word load.
        stall_addr = 32'h5004;
        stall_n = 3;
        c0 = cyc;
        push_ev(0, 32'h20, 32'h11);
        push_ev(0, 32'h21, 32'h22);
        push_ev(2, c0 + 8, 0);
        push_st(c0 + 5, 5'b10010);
        start_xfer(DirLoad, 32'h5000, 7'h20, 8'd2);
        repeat (10) @(negedge clk);
        stall_addr = 32'hFFFF_FFFF;

        // SRAM index wrap 126 -> 1.
        c0 = cyc;
        push_ev(0, 32'd126, 32'hB0);
        push_ev(0, 32'd127, 32'hB1);
        push_ev(0, 32'd0, 32'hB2);
        push_ev(0, 32'd1, 32'hB3);
        push_ev(2, c0 + 9, 0);
        start_xfer(DirLoad, 32'h3000, 7'd126, 8'd4);
        repeat (11) @(negedge clk);

        // Error on word 2 of a 5-word load.
        err_addr = 32'h4008;
        c0 = cyc;
        push_ev(0, 32'h40, 32'hC0);
        push_ev(0, 32'h41, 32'hC1);
        push_ev(2, c0 + 7, 0);
        push_st(c0 + 7, 5'b11100);
        push_st(c0 + 8, 5'b00100);
        start_xfer(DirLoad, 32'h4000, 7'h40, 8'd5);
        repeat (9) @(negedge clk);
        err_addr = 32'hFFFF_FFFF;

        // Zero-length start: done in cycle 1 and err cleared.
        c0 = cyc;
        push_ev(2, c0 + 1, 0);
        push_st(c0 + 1, 5'b11000);
        push_st(c0 + 2, 5'b00000);
        start_xfer(DirLoad, 32'h0, 7'd0, 8'd0);
        repeat (3) @(negedge clk);

        // Start pulse mid-transfer is ignored.
        c0 = cyc;
        for (int i = 0; i < 4; i++) push_ev(0, 32'h50 + i, 32'hA0 + i);
        push_ev(2, c0 + 9, 0);
        start_xfer(DirLoad, 32'h1000, 7'h50, 8'd4);
        @(negedge clk);
        start_xfer(DirStore, 32'h9000, 7'd5, 8'd1);
        repeat (10) @(negedge clk);

        // Reset mid-transfer: only word 0 lands, no done pulse.
        c0 = cyc;
        push_ev(0, 32'h60, 32'hA0);
        push_st(c0 + 4, 5'b00000);
        push_st(c0 + 5, 5'b00000);
        push_st(c0 + 6, 5'b00000);
        start_xfer(DirLoad, 32'h1000, 7'h60, 8'd4);
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);

        end_req = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL monitor did not close the run");
        $fatal(1);
    end

endmodule
